// File: rtl/rr_decoder_scheduler_if.sv
// rtl/rr_decoder_scheduler_if.sv - request/grant bundle between requesters and the round-robin scheduler
interface rr_decoder_scheduler_if;
   logic [31:0] req;
   logic        done;
   logic [4:0]  sel;
   logic        grant_valid;
   logic [31:0] grant;
   logic        timeout;

   modport master (
      output req,
      output done,
      input  sel,
      input  grant_valid,
      input  grant,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output sel,
      output grant_valid,
      output grant,
      output timeout
   );
endinterface

// File: rtl/rr_decoder_scheduler.sv
// rtl/rr_decoder_scheduler.sv - round-robin owner of the 32-way decoded select with hold timeout
module rr_decoder_scheduler #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   rr_decoder_scheduler_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [4:0]        ptr;
   logic [4:0]        sel_q;
   logic              valid_q;
   logic              timeout_q;
   logic [CNT_W-1:0]  hold_cnt;

   logic [31:0]       rot;
   logic [4:0]        pick;
   logic              any_req;
   logic              owner_req;
   logic              at_limit;

   // rot[i] is the request at distance i from ptr; the lowest set bit wins
   always_comb begin
      rot  = '0;
      pick = ptr;
      for (int i = 0; i < 32; i++) begin
         rot[i] = bus.req[5'(ptr + 5'(i))];
      end
      for (int i = 31; i >= 0; i--) begin
         if (rot[i]) pick = 5'(ptr + 5'(i));
      end
      any_req = |bus.req;
   end

   assign owner_req = bus.req[sel_q];
   assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  sel_q    <= pick;
                  valid_q  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (bus.done || !owner_req || at_limit) begin
                  // done outranks the timeout, so a coincident done suppresses the pulse
                  timeout_q <= !bus.done && owner_req;
                  valid_q   <= 1'b0;
                  ptr       <= sel_q + 5'd1;
                  state     <= IDLE;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel         = sel_q;
   assign bus.grant_valid = valid_q;
   assign bus.timeout     = timeout_q;
   assign bus.grant       = valid_q ? (32'd1 << sel_q) : 32'd0;
endmodule

// File: tb/tb_rr_decoder_scheduler.sv
// tb/tb_rr_decoder_scheduler.sv - directed bench for rr_decoder_scheduler with MAX_HOLD=4
module tb_rr_decoder_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   rr_decoder_scheduler_if bus_i ();

   rr_decoder_scheduler #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      bus_i.req  = 32'hFFFF_FFFF;
      bus_i.done = 1'b0;

      for (int i = 0; i < 3; i++) begin
         bus_i.done = ~bus_i.done;
         tick();
         check("rst_sel", 32'(bus_i.sel), 32'd0);
         check("rst_gv", 32'(bus_i.grant_valid), 32'd0);
         check("rst_grant", bus_i.grant, 32'd0);
         check("rst_to", 32'(bus_i.timeout), 32'd0);
      end
      bus_i.req  = 32'h0;
      bus_i.done = 1'b0;
      rst_n      = 1'b1;
      tick();
      check("idle_gv", 32'(bus_i.grant_valid), 32'd0);

      // single requester 5
      bus_i.req = 32'h0000_0020;
      tick();
      check("single_sel", 32'(bus_i.sel), 32'd5);
      check("single_grant", bus_i.grant, 32'h0000_0020);
      bus_i.done = 1'b1;
      tick();
      check("single_rel_gv", 32'(bus_i.grant_valid), 32'd0);
      check("single_rel_grant", bus_i.grant, 32'd0);
      check("single_rel_sel", 32'(bus_i.sel), 32'd5);
      bus_i.done = 1'b0;
      bus_i.req  = 32'hFFFF_FFFF;
      tick();
      check("ptr6_sel", 32'(bus_i.sel), 32'd6);

      // fairness: done held high, one idle cycle between grants
      bus_i.done = 1'b1;
      for (int i = 0; i <= 32; i++) begin
         check("fair_sel", 32'(bus_i.sel), 32'((6 + i) % 32));
         check("fair_gv", 32'(bus_i.grant_valid), 32'd1);
         tick();
         check("fair_idle", 32'(bus_i.grant_valid), 32'd0);
         if (i < 32) tick();
      end
      bus_i.done = 1'b0;
      bus_i.req  = 32'h0;
      tick();

      // wrap-around from ptr=30
      bus_i.req = 32'h2000_0000;
      tick();
      check("wrap_29", 32'(bus_i.sel), 32'd29);
      bus_i.done = 1'b1;
      tick();
      bus_i.done = 1'b0;
      bus_i.req  = 32'h0000_0003;
      tick();
      check("wrap_0a", 32'(bus_i.sel), 32'd0);
      check("wrap_0a_grant", bus_i.grant, 32'h0000_0001);
      bus_i.done = 1'b1;
      tick();
      tick();
      check("wrap_1", 32'(bus_i.sel), 32'd1);
      tick();
      tick();
      check("wrap_0b", 32'(bus_i.sel), 32'd0);
      tick();
      bus_i.done = 1'b0;
      bus_i.req  = 32'h0;
      tick();

      // timeout on requester 31
      bus_i.req = 32'h8000_0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("to_hold_gv", 32'(bus_i.grant_valid), 32'd1);
         check("to_hold_to", 32'(bus_i.timeout), 32'd0);
      end
      check("to_sel", 32'(bus_i.sel), 32'd31);
      tick();
      check("to_pulse", 32'(bus_i.timeout), 32'd1);
      check("to_rel_gv", 32'(bus_i.grant_valid), 32'd0);
      bus_i.req = 32'hFFFF_FFFF;
      tick();
      check("to_clear", 32'(bus_i.timeout), 32'd0);
      check("to_ptr0", 32'(bus_i.sel), 32'd0);

      // done on the timeout cycle suppresses the pulse
      tick();
      tick();
      tick();
      check("tod_gv", 32'(bus_i.grant_valid), 32'd1);
      bus_i.done = 1'b1;
      bus_i.req  = 32'h0000_0180;
      tick();
      check("tod_to", 32'(bus_i.timeout), 32'd0);
      check("tod_gv_rel", 32'(bus_i.grant_valid), 32'd0);
      bus_i.done = 1'b0;

      // withdraw by owner 7
      tick();
      check("wd_sel7", 32'(bus_i.sel), 32'd7);
      bus_i.req = 32'h0000_0100;
      tick();
      check("wd_rel", 32'(bus_i.grant_valid), 32'd0);
      check("wd_to", 32'(bus_i.timeout), 32'd0);
      tick();
      check("wd_sel8", 32'(bus_i.sel), 32'd8);
      check("wd_grant8", bus_i.grant, 32'h0000_0100);

      // asynchronous reset mid-BUSY
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_grant", bus_i.grant, 32'd0);
      check("arst_gv", 32'(bus_i.grant_valid), 32'd0);
      check("arst_sel", 32'(bus_i.sel), 32'd0);
      bus_i.req = 32'hFFFF_FFFF;
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_sel", 32'(bus_i.sel), 32'd0);
      check("post_rst_gv", 32'(bus_i.grant_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rr_decoder_scheduler.md
Name: rr_decoder_scheduler

Overview:
- Round-robin scheduler that shares the 32-line one-hot decoded select among 32 requesters.
- Picks one requester and drives a registered 5-bit select index (MSB-first, same bit order as the 5-to-32 decoder inputs) plus a gated one-hot grant.
- Holds each grant until the owner releases it, drops its request, or hits a hold timeout.
- Sits between the requesting units and the ALU/mux operand-select path.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held in BUSY; 0 disables the timeout.
- CNT_W, 8, width of the hold counter; MAX_HOLD must be less than 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req  input  32  request vector; bit k = requester k.
- done  input  1  release strobe from the current owner; sampled only in BUSY.
- sel  output  5  registered index of the current owner; sel[4] is the MSB (decoder i1).
- grant_valid  output  1  registered; high while a grant is held.
- grant  output  32  one-hot decode of sel, ANDed with grant_valid; all zeros when grant_valid=0.
- timeout  output  1  registered one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, ptr=0, hold_cnt=0
  - sel=0, grant_valid=0, grant=0, timeout=0
  - Deassertion is synchronous to clk.
- ptr (5 bits, internal) is the highest-priority index for the next arbitration.
- IDLE:
  - If req==0: stay in IDLE; outputs unchanged, grant_valid=0.
  - Else: pick k = first set bit of req scanning ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32).
  - Next edge: sel<=k, grant_valid<=1, hold_cnt<=0, state<=BUSY.
  - Latency from req sampled to grant visible: 1 cycle.
- BUSY: sel is frozen. Release conditions, evaluated each edge in priority order:
  1. done=1 → normal release, timeout stays 0.
  2. req[sel]=0 → owner withdrew; normal release.
  3. MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 → forced release; timeout<=1 for exactly one cycle.
  - Otherwise hold_cnt<=hold_cnt+1, saturating at 2^CNT_W-1.
- Release actions:
  - state<=IDLE, grant_valid<=0, ptr<=sel+1 (31 wraps to 0).
  - sel keeps its last value. grant is 0 because it is gated.
  - Each release forces one IDLE cycle, so consecutive grants are separated by one cycle with grant_valid=0. Peak throughput is 1 grant per 2 cycles when done is pulsed on the first BUSY cycle.
- Simultaneous done and timeout condition: done wins; timeout pulse is suppressed.
- Changes on req bits other than sel during BUSY have no effect.
- timeout returns to 0 on the edge after it is asserted.
- Reset mid-BUSY: grant drops asynchronously; ptr returns to 0, so post-reset fairness restarts at requester 0.
- No combinational path from req/done to any output. grant depends only on sel and grant_valid.

Test Plan:
- Reset: hold rst_n=0 with req=32'hFFFF_FFFF and done toggling → sel=0, grant_valid=0, grant=0, timeout=0. Assert rst_n low mid-BUSY → grant=0 immediately, without waiting for a clock edge.
- Single requester: req=32'h0000_0020 → one cycle later sel=5'b00101, grant=32'h0000_0020. Pulse done → next cycle grant_valid=0, ptr=6.
- Fairness: req=32'hFFFF_FFFF, done pulsed on each BUSY cycle → sel sequence 0,1,2,…,31,0. Each grant is separated by exactly one idle cycle.
- Wrap-around: ptr=30, req=32'h0000_0003 → grant goes to 0, then 1, then 0 (not stuck at 30/31).
- Timeout: MAX_HOLD=4, req=32'h8000_0000, done=0 → grant_valid high for 4 cycles, then timeout=1 for one cycle, grant_valid=0, ptr=0. Variant: assert done on the timeout cycle → timeout stays 0.
- Withdraw: owner 7 granted, req drops to 32'h0000_0100 → next edge grant_valid=0. The following grant goes to 8 after one idle cycle.
